// File: rtl/power_mode_ctrl.sv
// power_mode_ctrl: activity-windowed power-mode select with hysteresis, idle clock gating and force override
module power_mode_ctrl #(
  parameter int WINDOW = 16,
  parameter int HI_THRESH = 12,
  parameter int LO_THRESH = 4,
  parameter int LO_WINDOWS = 2,
  parameter int IDLE_GATE = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Op_Valid,
  input  logic       Force_Mode_En,
  input  logic [1:0] Force_Mode,
  output logic [1:0] Power_Mode,
  output logic       Clk_En,
  output logic       Mode_Change
);
  localparam logic [1:0] FULL = 2'b10;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] QUARTER = 2'b00;
  localparam int WW = $clog2(WINDOW);
  localparam int AW = $clog2(WINDOW + 1);
  localparam int LW = $clog2(LO_WINDOWS + 1);
  localparam int IW = $clog2(IDLE_GATE + 1);
  logic [WW-1:0] win_cnt;
  logic [AW-1:0] act_cnt, total;
  logic [LW-1:0] low_streak, streak_inc;
  logic [IW-1:0] idle_cnt;
  logic win_end, hi, lo, step, gated;
  logic [1:0] next_mode, down, forced;
  always_comb begin
    win_end = win_cnt == WW'(WINDOW - 1);
    total = act_cnt + AW'(Op_Valid);
    hi = total >= AW'(HI_THRESH);
    lo = total <= AW'(LO_THRESH);
    streak_inc = low_streak + 1'b1;
    step = lo && streak_inc == LW'(LO_WINDOWS);
    down = Power_Mode == FULL ? HALF : QUARTER;
    forced = Force_Mode == 2'b11 ? FULL : Force_Mode;
    next_mode = Force_Mode_En ? forced : !win_end ? Power_Mode : hi ? FULL : step ? down : Power_Mode;
    gated = idle_cnt == IW'(IDLE_GATE);
  end
  assign Clk_En = !gated || Op_Valid;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Power_Mode <= FULL;
      Mode_Change <= 1'b0;
      win_cnt <= '0;
      act_cnt <= '0;
      low_streak <= '0;
      idle_cnt <= '0;
    end else begin
      Power_Mode <= next_mode;
      Mode_Change <= next_mode != Power_Mode;
      idle_cnt <= Op_Valid ? '0 : gated ? idle_cnt : idle_cnt + 1'b1;
      if (Force_Mode_En) begin
        win_cnt <= '0;
        act_cnt <= '0;
        low_streak <= '0;
      end else begin
        win_cnt <= win_end ? '0 : win_cnt + 1'b1;
        act_cnt <= win_end ? '0 : total;
        low_streak <= !win_end ? low_streak : (lo && !step) ? streak_inc : '0;
      end
    end
  end
endmodule

// File: tb/tb_power_mode_ctrl.sv
// tb_power_mode_ctrl: randomized scoreboard bench for power_mode_ctrl against a window-level reference model
module tb_power_mode_ctrl;
  localparam int WINDOW = 16;
  localparam int HI_THRESH = 12;
  localparam int LO_THRESH = 4;
  localparam int LO_WINDOWS = 2;
  localparam int IDLE_GATE = 8;
  typedef struct {
    logic [1:0] mode;
    logic mc;
    logic en;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic op_valid = 1'b0;
  logic force_en = 1'b0;
  logic [1:0] force_mode = 2'b00;
  logic [1:0] power_mode;
  logic clk_en, mode_change;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int m_level = 2;
  logic m_mc = 1'b0;
  logic m_known = 1'b0;
  logic m_win[$];
  int m_streak = 0;
  int m_idle = 0;
  always #5 clk = ~clk;
  power_mode_ctrl #(
    .WINDOW(WINDOW), .HI_THRESH(HI_THRESH), .LO_THRESH(LO_THRESH),
    .LO_WINDOWS(LO_WINDOWS), .IDLE_GATE(IDLE_GATE)
  ) dut (
    .Clk(clk), .Rst(rst), .Op_Valid(op_valid), .Force_Mode_En(force_en),
    .Force_Mode(force_mode), .Power_Mode(power_mode), .Clk_En(clk_en),
    .Mode_Change(mode_change)
  );
  task automatic chk(input string n, input logic [1:0] a, input logic [1:0] x);
    checks++;
    if (a === x) passed++;
    else $display("FAIL %s at %0t: got %b expected %b", n, $time, a, x);
  endtask
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("power_mode", power_mode, e.mode);
      chk("mode_change", {1'b0, mode_change}, {1'b0, e.mc});
      chk("clk_en", {1'b0, clk_en}, {1'b0, e.en});
    end
  end
  task automatic cycle(input logic r, input logic v, input logic fe, input logic [1:0] fm);
    exp_t e;
    int old, a;
    @(negedge clk);
    rst = r;
    op_valid = v;
    force_en = fe;
    force_mode = fm;
    if (!r && m_known) begin
      e.mode = 2'(m_level);
      e.mc = m_mc;
      e.en = (m_idle < IDLE_GATE) || v;
      q.push_back(e);
    end
    if (r) begin
      m_known = 1'b1;
      m_level = 2;
      m_mc = 1'b0;
      m_win.delete();
      m_streak = 0;
      m_idle = 0;
    end else begin
      old = m_level;
      if (fe) begin
        m_level = (fm == 2'b11) ? 2 : int'(fm);
        m_win.delete();
        m_streak = 0;
      end else begin
        m_win.push_back(v);
        if (m_win.size() == WINDOW) begin
          a = 0;
          foreach (m_win[i]) a += int'(m_win[i]);
          m_win.delete();
          if (a >= HI_THRESH) begin
            m_level = 2;
            m_streak = 0;
          end else if (a <= LO_THRESH) begin
            m_streak++;
            if (m_streak == LO_WINDOWS) begin
              m_level = (m_level > 0) ? m_level - 1 : 0;
              m_streak = 0;
            end
          end else m_streak = 0;
        end
      end
      m_mc = m_level != old;
      m_idle = v ? 0 : m_idle + 1;
    end
  endtask
  task automatic window(input int n);
    int r;
    logic v;
    r = n;
    for (int c = WINDOW; c > 0; c--) begin
      v = int'($urandom_range(c - 1, 0)) < r;
      if (v) r--;
      cycle(1'b0, v, 1'b0, 2'b00);
    end
  endtask
  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 2'b00);
  endtask
  initial begin
    int p;
    logic v, fe, r;
    do_reset();
    window(WINDOW);
    window(3); window(3); window(3); window(3); window(3); window(3);
    window(12);
    repeat (4) window(3);
    window(11);
    window(3); window(11); window(3);
    do_reset();
    window(3); window(8); window(3);
    repeat (11) cycle(1'b0, 1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b1, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 1'b0, 2'b00);
    do_reset();
    window(2); window(2);
    cycle(1'b0, 1'b0, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 1'b1, 2'b11);
    cycle(1'b0, 1'b0, 1'b1, 2'b01);
    cycle(1'b1, 1'b0, 1'b1, 2'b00);
    window(13); window(0); window(0);
    window(1);
    do_reset();
    repeat (WINDOW - 1) cycle(1'b0, 1'b1, 1'b0, 2'b00);
    cycle(1'b0, 1'b0, 1'b1, 2'b10);
    window(0); window(0);
    cycle(1'b0, 1'b0, 1'b1, 2'b00);
    cycle(1'b0, 1'b0, 1'b1, 2'b00);
    window(WINDOW);
    p = 50;
    for (int i = 0; i < 1200; i++) begin
      if (i % 96 == 0) p = 25 * int'($urandom_range(4, 0));
      v = int'($urandom_range(99, 0)) < p;
      fe = $urandom_range(39, 0) == 0;
      r = $urandom_range(299, 0) == 0;
      cycle(r, v, fe, 2'($urandom_range(3, 0)));
    end
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
